// File: rtl/pwm_sample_player.sv
// pwm_sample_player
//   Buffers unsigned audio samples in a small FIFO, takes one sample per sample
//   strobe (tick) into a shadow register, and plays the shadow value as a
//   single-bit PWM stream. The shadow is copied into the active duty value only
//   at a PWM period boundary, so a period is never cut short or stretched.
//
//   Build option: define UNDERRUN_MUTE_EN to make an underrun load mid-scale
//   (2**(DATA_W-1)) into the shadow instead of holding the last sample.
//
//   Handshake (in_valid / in_ready): a sample is transferred on every rising
//   clock edge where in_valid && in_ready are both high. in_ready depends only
//   on the registered FIFO occupancy (it is low exactly when the FIFO is full),
//   never on in_valid, so upstream must hold in_data/in_valid stable until the
//   transfer edge. Nothing is dropped when full; the sample waits upstream.
module pwm_sample_player #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic                  pwm_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Occupancy constants; full is the only value with the top bit set.
    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LEVEL_ZERO = '0;
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]     CNT_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]     CNT_LAST   = '1;
`ifdef UNDERRUN_MUTE_EN
    localparam logic [DATA_W-1:0]     MUTE_LEVEL = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // Sample path and PWM state
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic [DATA_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                  pwm_out_q, pwm_out_d;
    logic                  underrun_q, underrun_d;

    // Transfer qualifiers, all decided on pre-edge occupancy
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  period_wrap;

    assign fifo_empty  = (count_q == LEVEL_ZERO);
    assign in_ready    = (count_q != LEVEL_FULL);
    assign push        = in_valid && in_ready;
    assign pop         = tick && !fifo_empty;
    assign period_wrap = (pwm_cnt_q == CNT_LAST);

    assign level    = count_q;
    assign underrun = underrun_q;
    assign pwm_out  = pwm_out_q;

    // FIFO pointer and occupancy next-state; a push into an empty FIFO in the
    // same cycle as a tick is stored but cannot satisfy that tick.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LEVEL_ONE;
            2'b01:   count_d = count_q - LEVEL_ONE;
            default: count_d = count_q;
        endcase
    end

    // Shadow capture on tick, underrun detection
    always_comb begin
        shadow_d   = shadow_q;
        underrun_d = tick && fifo_empty;
        if (pop) begin
            shadow_d = mem_q[rd_ptr_q];
        end
`ifdef UNDERRUN_MUTE_EN
        if (underrun_d) begin
            shadow_d = MUTE_LEVEL;
        end
`endif
    end

    // PWM counter, period-boundary duty update and output compare
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + CNT_ONE;
        active_d  = active_q;
        if (period_wrap) begin
            active_d = shadow_q;
        end
        pwm_out_d = (pwm_cnt_q < active_q);
    end

    // FIFO data array; contents need no reset since occupancy gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            pwm_cnt_q  <= '0;
            pwm_out_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_out_q  <= pwm_out_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
